// File: rtl/apb_conv_pkg.sv
// Shared constants, types and FSM encoding for the APB width down-converter.
package apb_conv_pkg;

    localparam int DEF_ADDR_WIDTH    = 13;
    localparam int DEF_UP_DATA_WIDTH = 64;
    localparam int DEF_DN_DATA_WIDTH = 32;

    // Narrow beats per wide transfer, and bytes per narrow beat.
    localparam int NBEATS    = DEF_UP_DATA_WIDTH / DEF_DN_DATA_WIDTH;
    localparam int DN_NBYTES = DEF_DN_DATA_WIDTH / 8;

    typedef logic [DEF_UP_DATA_WIDTH-1:0] up_data_t;
    typedef logic [DEF_DN_DATA_WIDTH-1:0] dn_data_t;
    typedef logic [DEF_ADDR_WIDTH-1:0]    addr_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/apb_conv_if.sv
// APB3 bus bundle; master drives the request side, slave drives the response.
interface apb_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_converter.sv
// APB3 down-converter: each wide upstream transfer becomes NBEATS narrow
// downstream transfers at consecutive addresses, big-endian (MSW first).
module apb_converter
    import apb_conv_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int UP_DATA_WIDTH = DEF_UP_DATA_WIDTH,
    parameter int DN_DATA_WIDTH = DEF_DN_DATA_WIDTH
) (
    input logic   PCLK,
    input logic   PRESETn,
    apb_if.slave  s_apb,
    apb_if.master m_apb
);

    localparam int BEATS      = UP_DATA_WIDTH / DN_DATA_WIDTH;
    localparam int BEAT_BYTES = DN_DATA_WIDTH / 8;
    localparam int KW         = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                   state;
    logic [KW-1:0]            k;
    logic                     wr_q;
    logic [UP_DATA_WIDTH-1:0] wdata_q;
    logic [UP_DATA_WIDTH-1:0] rd_buf;
    logic [UP_DATA_WIDTH-1:0] rd_next;

    // Beat idx of a wide word; beat 0 is the most significant slice.
    function automatic logic [DN_DATA_WIDTH-1:0] beat_of(
        input logic [UP_DATA_WIDTH-1:0] d,
        input logic [KW-1:0]            idx
    );
        return d[UP_DATA_WIDTH-1-int'(idx)*DN_DATA_WIDTH -: DN_DATA_WIDTH];
    endfunction

    // Read assembly: current downstream read data merged into slice k.
    always_comb begin
        rd_next = rd_buf;
        rd_next[UP_DATA_WIDTH-1-int'(k)*DN_DATA_WIDTH -: DN_DATA_WIDTH] = m_apb.prdata;
    end

    // Converter FSM; every bus output is registered here.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state           <= IDLE;
            k               <= '0;
            wr_q            <= 1'b0;
            wdata_q         <= '0;
            rd_buf          <= '0;
            s_apb.prdata    <= '0;
            s_apb.pready    <= 1'b0;
            s_apb.pslverr   <= 1'b0;
            m_apb.paddr     <= '0;
            m_apb.psel      <= 1'b0;
            m_apb.penable   <= 1'b0;
            m_apb.pwrite    <= 1'b0;
            m_apb.pwdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_apb.psel) begin
                        wr_q    <= s_apb.pwrite;
                        wdata_q <= s_apb.pwdata;
                        k       <= '0;
                        if (s_apb.paddr % ADDR_WIDTH'(BEAT_BYTES) != '0) begin
                            // Misaligned: answer with an error, never touch the narrow bus.
                            state         <= RESP;
                            s_apb.pready  <= 1'b1;
                            s_apb.pslverr <= 1'b1;
                        end else begin
                            state         <= SETUP;
                            m_apb.psel    <= 1'b1;
                            m_apb.penable <= 1'b0;
                            m_apb.paddr   <= s_apb.paddr;
                            m_apb.pwrite  <= s_apb.pwrite;
                            m_apb.pwdata  <= s_apb.pwrite ? beat_of(s_apb.pwdata, '0) : '0;
                        end
                    end
                end
                SETUP: begin
                    m_apb.penable <= 1'b1;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    if (m_apb.pready) begin
                        if (!wr_q) rd_buf <= rd_next;
                        if (m_apb.pslverr || k == KW'(BEATS-1)) begin
                            // Last beat or error: remaining beats are dropped.
                            state         <= RESP;
                            m_apb.psel    <= 1'b0;
                            m_apb.penable <= 1'b0;
                            m_apb.pwdata  <= '0;
                            s_apb.pready  <= 1'b1;
                            s_apb.pslverr <= m_apb.pslverr;
                            if (!wr_q && !m_apb.pslverr) s_apb.prdata <= rd_next;
                        end else begin
                            // Next beat gets its own setup phase; address wraps naturally.
                            state         <= SETUP;
                            k             <= k + 1'b1;
                            m_apb.penable <= 1'b0;
                            m_apb.paddr   <= m_apb.paddr + ADDR_WIDTH'(BEAT_BYTES);
                            m_apb.pwdata  <= wr_q ? beat_of(wdata_q, k + 1'b1) : '0;
                        end
                    end
                end
                RESP: begin
                    s_apb.pready  <= 1'b0;
                    s_apb.pslverr <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_converter.sv
// Scoreboard bench for apb_converter: wide master driver, narrow memory slave.
module tb_apb_converter;
    import apb_conv_pkg::*;

    typedef struct packed {
        addr_t    addr;
        logic     wr;
        dn_data_t data;
    } dn_beat_t;

    typedef struct packed {
        up_data_t rdata;
        logic     err;
        int       lat;
    } up_rsp_t;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_if #(.ADDR_WIDTH(DEF_ADDR_WIDTH), .DATA_WIDTH(DEF_UP_DATA_WIDTH)) up_if ();
    apb_if #(.ADDR_WIDTH(DEF_ADDR_WIDTH), .DATA_WIDTH(DEF_DN_DATA_WIDTH)) dn_if ();

    apb_converter dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .s_apb   (up_if),
        .m_apb   (dn_if)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    dn_beat_t dn_exp[$];
    up_rsp_t  up_exp[$];
    logic [7:0] dmem [0:8191];
    logic [7:0] rmem [0:8191];
    up_data_t   exp_prdata = '0;

    // Downstream slave knobs, owned by the stimulus process.
    logic  wait_en = 1'b0;
    addr_t wait_addr = '0;
    int    wait_n = 0;
    logic  err_en = 1'b0;
    addr_t err_addr = '0;

    int       wcnt = 0;
    int       psel_cycles = 0;
    logic     mem_init = 1'b0;
    dn_beat_t e;
    int       dn_wait;
    logic     dn_acc;

    always_comb begin
        dn_acc  = dn_if.psel & dn_if.penable;
        dn_wait = (wait_en && dn_if.paddr == wait_addr) ? wait_n : 0;
    end
    assign dn_if.pready  = dn_acc && (wcnt >= dn_wait);
    assign dn_if.pslverr = dn_if.pready && err_en && (dn_if.paddr == err_addr);

    always_comb begin
        dn_if.prdata = '0;
        for (int i = 0; i < DN_NBYTES; i++)
            dn_if.prdata[DEF_DN_DATA_WIDTH-1-8*i -: 8] = dmem[addr_t'(dn_if.paddr + addr_t'(i))];
    end

    // Narrow slave memory plus downstream monitor against the beat scoreboard.
    always @(posedge PCLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 8192; i++) dmem[i] <= 8'h00;
            mem_init <= 1'b1;
        end
        if (dn_if.psel) psel_cycles <= psel_cycles + 1;
        if (dn_acc && !dn_if.pready) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (dn_acc && dn_if.pready) begin
            if (dn_exp.size() == 0) begin
                chk("dn_unexpected_beat", 64'(dn_if.paddr), 64'hFFFF);
            end else begin
                e = dn_exp.pop_front();
                chk("dn_addr",  64'(dn_if.paddr),  64'(e.addr));
                chk("dn_write", 64'(dn_if.pwrite), 64'(e.wr));
                chk("dn_wdata", 64'(dn_if.pwdata), 64'(e.data));
            end
            if (dn_if.pwrite && !dn_if.pslverr)
                for (int i = 0; i < DN_NBYTES; i++)
                    dmem[addr_t'(dn_if.paddr + addr_t'(i))] <= dn_if.pwdata[DEF_DN_DATA_WIDTH-1-8*i -: 8];
        end
    end

    // One upstream transfer: push expectations, drive APB, compare response.
    task automatic up_xfer(input addr_t a, input logic wr, input up_data_t wd,
                           input int nwait, input logic err0);
        logic    aligned;
        int      nb;
        int      cyc;
        int      snap;
        up_rsp_t r;
        up_rsp_t g;
        aligned = (int'(a) % DN_NBYTES) == 0;
        nb = !aligned ? 0 : (err0 ? 1 : NBEATS);
        for (int k = 0; k < nb; k++)
            dn_exp.push_back('{addr: addr_t'(a + addr_t'(k*DN_NBYTES)), wr: wr,
                               data: wr ? wd[DEF_UP_DATA_WIDTH-1-k*DEF_DN_DATA_WIDTH -: DEF_DN_DATA_WIDTH] : '0});
        if (aligned && !err0) begin
            for (int i = 0; i < DEF_UP_DATA_WIDTH/8; i++) begin
                if (wr) rmem[addr_t'(a + addr_t'(i))] = wd[DEF_UP_DATA_WIDTH-1-8*i -: 8];
                else    exp_prdata[DEF_UP_DATA_WIDTH-1-8*i -: 8] = rmem[addr_t'(a + addr_t'(i))];
            end
        end
        r.rdata = exp_prdata;
        r.err   = !aligned || err0;
        r.lat   = aligned ? (2*nb + 1 + nwait) : 1;
        up_exp.push_back(r);

        wait_en = (nwait > 0); wait_addr = a; wait_n = nwait;
        err_en  = err0;        err_addr  = a;
        snap = psel_cycles;

        @(posedge PCLK); #1;
        up_if.paddr = a; up_if.pwrite = wr; up_if.pwdata = wd;
        up_if.psel = 1'b1; up_if.penable = 1'b0;
        @(posedge PCLK); #1;
        up_if.penable = 1'b1;
        cyc = 1;
        while (!up_if.pready && cyc < 64) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        chk("rsp_pready", 64'(up_if.pready), 64'd1);
        if (up_if.pready) begin
            g = up_exp.pop_front();
            chk("rsp_prdata",  up_if.prdata,        g.rdata);
            chk("rsp_pslverr", 64'(up_if.pslverr), 64'(g.err));
            chk("rsp_latency", 64'(cyc),           64'(g.lat));
        end
        if (!aligned) chk("unaligned_no_m_psel", 64'(psel_cycles - snap), 64'd0);
        @(posedge PCLK); #1;
        up_if.psel = 1'b0; up_if.penable = 1'b0;
        wait_en = 1'b0; err_en = 1'b0;
        chk("rsp_pready_one_cycle", 64'(up_if.pready), 64'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 8192; i++) rmem[i] = 8'h00;
        up_if.paddr = '0; up_if.psel = 1'b0; up_if.penable = 1'b0;
        up_if.pwrite = 1'b0; up_if.pwdata = '0;

        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        chk("rst_s_prdata",  up_if.prdata,        64'd0);
        chk("rst_s_pready",  64'(up_if.pready),  64'd0);
        chk("rst_s_pslverr", 64'(up_if.pslverr), 64'd0);
        chk("rst_m_paddr",   64'(dn_if.paddr),   64'd0);
        chk("rst_m_psel",    64'(dn_if.psel),    64'd0);
        chk("rst_m_penable", 64'(dn_if.penable), 64'd0);
        chk("rst_m_pwrite",  64'(dn_if.pwrite),  64'd0);
        chk("rst_m_pwdata",  64'(dn_if.pwdata),  64'd0);

        // Directed aligned transfers, including the top-of-space wrap.
        up_xfer(13'h000, 1'b1, 64'h0011223344556677, 0, 1'b0);
        up_xfer(13'h000, 1'b0, '0, 0, 1'b0);
        up_xfer(13'h004, 1'b1, 64'hDEADBEEFCAFEF00D, 0, 1'b0);
        up_xfer(13'h004, 1'b0, '0, 0, 1'b0);
        up_xfer(13'h1FFC, 1'b1, 64'hA1B2C3D4E5F60718, 0, 1'b0);
        up_xfer(13'h1FFC, 1'b0, '0, 0, 1'b0);

        // Byte-address sweep: aligned ones round-trip, others error out.
        for (int a = 0; a <= 248; a++) begin
            up_xfer(addr_t'(a), 1'b1, {$urandom, $urandom}, 0, 1'b0);
            up_xfer(addr_t'(a), 1'b0, '0, 0, 1'b0);
        end

        // Wait states on beat 0.
        up_xfer(13'h100, 1'b1, 64'h0123456789ABCDEF, 3, 1'b0);
        up_xfer(13'h100, 1'b0, '0, 3, 1'b0);

        // Slave error on beat 0 of a write: beat 1 must not happen.
        up_xfer(13'h200, 1'b1, 64'hFFEEDDCCBBAA9988, 0, 1'b1);
        up_xfer(13'h200, 1'b0, '0, 0, 1'b0);

        // Reset in the middle of a stalled access phase.
        wait_en = 1'b1; wait_addr = 13'h040; wait_n = 8;
        @(posedge PCLK); #1;
        up_if.paddr = 13'h040; up_if.pwrite = 1'b0; up_if.psel = 1'b1; up_if.penable = 1'b0;
        @(posedge PCLK); #1;
        up_if.penable = 1'b1;
        cyc = 0;
        while (!(dn_if.psel && dn_if.penable) && cyc < 20) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        chk("mr_in_access", 64'(dn_if.penable), 64'd1);
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        up_if.psel = 1'b0; up_if.penable = 1'b0;
        chk("mr_m_psel",    64'(dn_if.psel),    64'd0);
        chk("mr_m_penable", 64'(dn_if.penable), 64'd0);
        chk("mr_s_pready",  64'(up_if.pready),  64'd0);
        chk("mr_s_prdata",  up_if.prdata,       64'd0);
        repeat (2) begin
            @(posedge PCLK); #1;
            chk("mr_no_pready", 64'(up_if.pready), 64'd0);
        end
        PRESETn = 1'b1; wait_en = 1'b0;
        exp_prdata = '0;
        up_xfer(13'h008, 1'b0, '0, 0, 1'b0);
        up_xfer(13'h010, 1'b1, 64'h5A5A5A5AC3C3C3C3, 0, 1'b0);
        up_xfer(13'h010, 1'b0, '0, 0, 1'b0);

        repeat (4) @(posedge PCLK);
        chk("dn_scoreboard_empty", 64'(dn_exp.size()), 64'd0);
        chk("up_scoreboard_empty", 64'(up_exp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
